muldiv_seq: RTL and testbench

- Iterative unsigned multiply/divide sequencer producing MIPS-style HI/LO results.
- Owns no adder: it drives the shared ALU's aluop/portA/portB each cycle and consumes portOut.
- Sits beside the execute stage. The pipeline issues MULTU/DIVU through a start/busy/done handshake.
- While busy, the sequencer owns the ALU. The pipeline stalls dependent instructions and muxes ALU inputs to this block when alu_grant is high.

---
 rtl/muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned MULTU/DIVU sequencer producing MIPS-style HI/LO.
//
// The block owns no adder. It borrows the shared execute-stage ALU through
// alu_grant/alu_aluop/alu_portA/alu_portB and consumes alu_portOut, running one
// shift-add (multiply) or restoring-subtract (divide) iteration per cycle.
//
// Handshake: the pipeline pulses start (sampled only in IDLE) with op/rs/rt.
// busy is high from the cycle after the accepted start until the cycle after
// done. done pulses for exactly one cycle when hi/lo/div0 become valid. flush
// abandons any operation and suppresses done.
//
// Ports:
//   CLK, nRST           clock (rising edge), synchronous active-low reset
//   start, op, rs, rt   request: op 0 = MULTU, 1 = DIVU; rs/rt operands
//   flush               squash in-flight operation (beats start in IDLE)
//   busy, done          status / one-cycle completion pulse
//   div0                last accepted DIVU had rt = 0 (valid with hi/lo)
//   hi, lo              MULTU: product high/low; DIVU: remainder/quotient
//   alu_grant           sequencer drives the shared ALU this cycle
//   alu_aluop/portA/B   ALU request; alu_portOut is the ALU result
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            div0,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            alu_grant,
    output logic [3:0]      alu_aluop,
    output logic [XLEN-1:0] alu_portA,
    output logic [XLEN-1:0] alu_portB,
    input  logic [XLEN-1:0] alu_portOut
);

    // aluop_t encodings used by the shared ALU
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    // hi_q/lo_q double as rem/quot during a divide, so the final copy to
    // HI/LO is implicit.
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    // Multiplicand for MULTU, divisor for DIVU.
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div0_q, div0_d;

    logic            carry;
    logic            rmsb;
    logic [XLEN-1:0] rsh;
    logic            ge;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        div0_d    = div0_q;
        alu_grant = 1'b0;
        alu_aluop = ALU_ADD;
        alu_portA = '0;
        alu_portB = '0;
        carry     = 1'b0;
        rmsb      = 1'b0;
        rsh       = '0;
        ge        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!flush && start) begin
                    cnt_d = '0;
                    if (!op) begin
                        hi_d    = '0;
                        lo_d    = rt;
                        opnd_d  = rs;
                        div0_d  = 1'b0;
                        state_d = MUL;
                    end else if (rt != '0) begin
                        hi_d    = '0;
                        lo_d    = rs;
                        opnd_d  = rt;
                        div0_d  = 1'b0;
                        state_d = DIV;
                    end else begin
                        // Divide by zero completes immediately with the
                        // MIPS-convention result.
                        hi_d    = rs;
                        lo_d    = '1;
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            MUL: begin
                alu_grant = 1'b1;
                alu_aluop = ALU_ADD;
                alu_portA = hi_q;
                alu_portB = lo_q[0] ? opnd_q : '0;
                // Unsigned wrap of the sum means a carry out of the top bit.
                carry     = (alu_portOut < hi_q);
                hi_d      = {carry, alu_portOut[XLEN-1:1]};
                lo_d      = {alu_portOut[0], lo_q[XLEN-1:1]};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
                if (flush) begin
                    state_d = IDLE;
                end
            end

            DIV: begin
                {rmsb, rsh} = {hi_q, lo_q[XLEN-1]};
                alu_grant   = 1'b1;
                alu_aluop   = ALU_SUB;
                alu_portA   = rsh;
                alu_portB   = opnd_q;
                // A set bit shifted out of rem means the true partial
                // remainder exceeds 2^XLEN and certainly covers the divisor;
                // the modulo-2^XLEN difference is still the exact result.
                ge          = rmsb | (rsh >= opnd_q);
                hi_d        = ge ? alu_portOut : rsh;
                lo_d        = {lo_q[XLEN-2:0], ge};
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
                if (flush) begin
                    state_d = IDLE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq. Provides a behavioural stand-in for the
// shared ALU (ADD/SUB only), issues MULTU/DIVU requests with hand-computed
// results and checks latency, ALU ownership, flush and reset behaviour.
module tb_muldiv_seq;

    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic        op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_grant;
    logic [3:0]  alu_aluop;
    logic [31:0] alu_portA;
    logic [31:0] alu_portB;
    logic [31:0] alu_portOut;

    int total = 0;
    int bad   = 0;

    // Expected results: {div0, hi, lo}
    logic [64:0] exp_q[$];

    muldiv_seq dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .start       (start),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div0        (div0),
        .hi          (hi),
        .lo          (lo),
        .alu_grant   (alu_grant),
        .alu_aluop   (alu_aluop),
        .alu_portA   (alu_portA),
        .alu_portB   (alu_portB),
        .alu_portOut (alu_portOut)
    );

    // Shared ALU stand-in
    assign alu_portOut = (alu_aluop == ALU_SUB) ? (alu_portA - alu_portB)
                                                : (alu_portA + alu_portB);

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one operation and follow it to done. Called 1 unit after an edge
    // with the DUT idle. If intr > 0 a different start is pulsed so that it is
    // sampled at edge intr of the operation; it must be ignored.
    task automatic run_op(input string name, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh,
                          input logic [31:0] el, input logic ed,
                          input int elat, input int egrant, input int intr);
        int n;
        int g;
        logic [64:0] e;
        exp_q.push_back({ed, eh, el});
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        tick();
        start = 1'b0;
        n = 0;
        g = 0;
        while (!done && n < 100) begin
            if (alu_grant) g++;
            if (n == 0 && egrant > 0) begin
                check_eq({name, "_aluop"}, 64'(alu_aluop), 64'(o ? ALU_SUB : ALU_ADD));
            end
            if (intr > 0 && n == intr - 1) begin
                start = 1'b1;
                op    = 1'b1;
                rs    = 32'hDEAD_BEEF;
                rt    = 32'h0;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check_eq({name, "_done"}, 64'(done), 64'd1);
        check_eq({name, "_lat"}, 64'(n), 64'(elat));
        check_eq({name, "_grant_cycles"}, 64'(g), 64'(egrant));
        check_eq({name, "_busy_at_done"}, 64'(busy), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({name, "_hi"}, 64'(hi), 64'(e[63:32]));
            check_eq({name, "_lo"}, 64'(lo), 64'(e[31:0]));
            check_eq({name, "_div0"}, 64'(div0), 64'(e[64]));
        end
        tick();
        check_eq({name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
        check_eq({name, "_hold"}, {hi, lo}, {eh, el});
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_busy"}, 64'(busy), 64'd0);
        check_eq({name, "_done"}, 64'(done), 64'd0);
        check_eq({name, "_div0"}, 64'(div0), 64'd0);
        check_eq({name, "_hilo"}, {hi, lo}, 64'd0);
        check_eq({name, "_grant"}, 64'(alu_grant), 64'd0);
        check_eq({name, "_aluop"}, 64'(alu_aluop), 64'(ALU_ADD));
        check_eq({name, "_ports"}, {alu_portA, alu_portB}, 64'd0);
    endtask

    initial begin
        int seen;
        nRST  = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        rs    = '0;
        rt    = '0;
        flush = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        nRST = 1'b1;
        tick();

        run_op("mul_7x6",   1'b0, 32'd7,         32'd6,         32'h0,        32'd42,        1'b0, 32, 32, 0);
        run_op("mul_full",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32, 32, 0);
        run_op("div_100_7", 1'b1, 32'd100,       32'd7,         32'd2,        32'd14,        1'b0, 32, 32, 0);
        run_op("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,        32'hFFFF_FFFF, 1'b0, 32, 32, 0);
        run_op("div_5_9",   1'b1, 32'd5,         32'd9,         32'd5,        32'd0,         1'b0, 32, 32, 0);
        run_op("div_by0",   1'b1, 32'h1234,      32'd0,         32'h1234,     32'hFFFF_FFFF, 1'b1, 0,  0,  0);
        run_op("mul_3x3",   1'b0, 32'd3,         32'd3,         32'd0,        32'd9,         1'b0, 32, 32, 0);
        // 0x10000 * 0x30000 = 0x3_0000_0000; intruding DIVU by zero must not land
        run_op("mul_intr",  1'b0, 32'h0001_0000, 32'h0003_0000, 32'd3,        32'd0,         1'b0, 32, 32, 10);

        // Flush in the middle of a multiply
        start = 1'b1;
        op    = 1'b0;
        rs    = 32'd5;
        rt    = 32'd5;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check_eq("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        check_eq("flush_grant", 64'(alu_grant), 64'd0);
        seen = 0;
        repeat (4) begin
            if (done || busy) seen = 1;
            tick();
        end
        check_eq("flush_no_done", 64'(seen), 64'd0);

        // Flush beats start in IDLE
        flush = 1'b1;
        start = 1'b1;
        op    = 1'b1;
        rs    = 32'd1;
        rt    = 32'd0;
        tick();
        flush = 1'b0;
        start = 1'b0;
        check_eq("idle_flush_busy", {62'd0, busy, done}, 64'd0);

        run_op("div_after_flush", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32, 32, 0);

        // Reset in the middle of a divide
        start = 1'b1;
        op    = 1'b1;
        rs    = 32'd100;
        rt    = 32'd7;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check_eq("rst_mid_pre_grant", 64'(alu_grant), 64'd1);
        nRST = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        nRST = 1'b1;
        seen = 0;
        repeat (4) begin
            tick();
            if (done || busy) seen = 1;
        end
        check_eq("rst_mid_no_done", 64'(seen), 64'd0);

        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
